// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Holds the TX-queue FSM state enum and the default data width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock circular FIFO with registered occupancy.
// Ports: clk, rst (async high), wr_en/wr_data, rd_en/rd_data
// (rd_data shows the head entry), full, empty, level (0..DEPTH).
module uart_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    // Writes into a full queue and reads from an empty one are ignored.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Flags follow the registered level, so they change one edge
    // after the access that moved it.
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered UART transmit front-end: host bytes queue in a FIFO and are
// launched one per frame via tx_start/tx_data, gated by tx_done edges.
// Ports: clk, rst (async high), wr_en/wr_data (host), tx_en, tx_done,
// tx_start, tx_data, full, empty, level, busy.
// Optional macro UART_TXQ_OVF_EN adds ovf_clr (in) and sticky ovf (out).
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tx_en,
    input  logic              tx_done,
`ifdef UART_TXQ_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf,
`endif
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level,
    output logic              busy
);

    txq_state_t        state;
    txq_state_t        state_nx;
    logic              tx_done_q;
    logic              done_rise;
    logic              pop;
    logic [DATA_W-1:0] head;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Edge detect so a done level held from the last frame is not
    // taken as completion of the next one.
    assign done_rise = tx_done && !tx_done_q;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        tx_start = 1'b0;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_en && !empty) begin
                    // Pop on the way into LAUNCH so tx_data is
                    // valid for the whole tx_start cycle.
                    pop      = 1'b1;
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start = 1'b1;
                busy     = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (done_rise) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_done_q <= 1'b0;
            tx_data   <= '0;
        end else begin
            state     <= state_nx;
            tx_done_q <= tx_done;
            if (pop) begin
                tx_data <= head;
            end
        end
    end

`ifdef UART_TXQ_OVF_EN
    // Sticky drop flag; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a directed vector table for
// launch/handshake timing plus sequences for fill, wrap and reset.
module tb_uart_tx_queue;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       tx_en = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       busy;
`ifdef UART_TXQ_OVF_EN
    logic       ovf_clr = 1'b0;
    logic       ovf;
`endif

    int total = 0;
    int passed = 0;
    logic [7:0] q[$];

    uart_tx_queue #(.DEPTH(16), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_en    (tx_en),
        .tx_done  (tx_done),
`ifdef UART_TXQ_OVF_EN
        .ovf_clr  (ovf_clr),
        .ovf      (ovf),
`endif
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       en;
        logic       done;
        logic       st;
        logic [7:0] td;
        logic [4:0] lvl;
        logic       emp;
        logic       bsy;
    } vec_t;

    vec_t tv [26];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        q.push_back(b);
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (!tx_start && t < 20) begin
                step();
                t++;
            end
            if (!tx_start) begin
                chk("launch_timeout", 32'(tx_start), 32'd1);
                return;
            end
            chk($sformatf("drain_data_%0d", k), 32'(tx_data),
                32'(q.pop_front()));
            step();
            tx_done = 1'b1;
            step();
            chk("drain_idle", 32'(busy), 32'd0);
            tx_done = 1'b0;
            step();
        end
    endtask

    initial begin
        tv[0]  = '{1, 8'hA5, 1, 0, 0, 8'h00, 1, 0, 0};
        tv[1]  = '{0, 8'h00, 1, 0, 1, 8'hA5, 0, 1, 1};
        tv[2]  = '{0, 8'h00, 1, 0, 0, 8'hA5, 0, 1, 1};
        tv[3]  = '{0, 8'h00, 1, 1, 0, 8'hA5, 0, 1, 0};
        tv[4]  = '{0, 8'h00, 1, 0, 0, 8'hA5, 0, 1, 0};
        tv[5]  = '{1, 8'h11, 1, 0, 0, 8'hA5, 1, 0, 0};
        tv[6]  = '{1, 8'h22, 1, 0, 1, 8'h11, 1, 0, 1};
        tv[7]  = '{1, 8'h33, 1, 0, 0, 8'h11, 2, 0, 1};
        tv[8]  = '{0, 8'h00, 1, 0, 0, 8'h11, 2, 0, 1};
        tv[9]  = '{0, 8'h00, 1, 1, 0, 8'h11, 2, 0, 0};
        tv[10] = '{0, 8'h00, 1, 1, 1, 8'h22, 1, 0, 1};
        tv[11] = '{0, 8'h00, 1, 1, 0, 8'h22, 1, 0, 1};
        tv[12] = '{0, 8'h00, 1, 1, 0, 8'h22, 1, 0, 1};
        tv[13] = '{0, 8'h00, 1, 0, 0, 8'h22, 1, 0, 1};
        tv[14] = '{0, 8'h00, 1, 1, 0, 8'h22, 1, 0, 0};
        tv[15] = '{0, 8'h00, 1, 0, 1, 8'h33, 0, 1, 1};
        tv[16] = '{0, 8'h00, 1, 0, 0, 8'h33, 0, 1, 1};
        tv[17] = '{0, 8'h00, 1, 1, 0, 8'h33, 0, 1, 0};
        tv[18] = '{0, 8'h00, 1, 0, 0, 8'h33, 0, 1, 0};
        tv[19] = '{1, 8'h44, 1, 0, 0, 8'h33, 1, 0, 0};
        tv[20] = '{0, 8'h00, 1, 0, 1, 8'h44, 0, 1, 1};
        tv[21] = '{0, 8'h00, 1, 1, 0, 8'h44, 0, 1, 1};
        tv[22] = '{0, 8'h00, 1, 1, 0, 8'h44, 0, 1, 1};
        tv[23] = '{0, 8'h00, 1, 0, 0, 8'h44, 0, 1, 1};
        tv[24] = '{0, 8'h00, 1, 1, 0, 8'h44, 0, 1, 0};
        tv[25] = '{0, 8'h00, 0, 0, 0, 8'h44, 0, 1, 0};

        // Reset state
        step();
        step();
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
`ifdef UART_TXQ_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Vector table: launch latency, ordering, done edge handling
        foreach (tv[i]) begin
            wr_en   = tv[i].wr;
            wr_data = tv[i].d;
            tx_en   = tv[i].en;
            tx_done = tv[i].done;
            step();
            chk($sformatf("v%0d_start", i), 32'(tx_start), 32'(tv[i].st));
            chk($sformatf("v%0d_data", i), 32'(tx_data), 32'(tv[i].td));
            chk($sformatf("v%0d_level", i), 32'(level), 32'(tv[i].lvl));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tv[i].emp));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].bsy));
        end
        wr_en = 1'b0;
        tx_done = 1'b0;

        // Fill to DEPTH with launches blocked, then overflow write
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_idle", 32'(busy), 32'd0);
        wr_en = 1'b1;
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_full", 32'(full), 32'd1);
`ifdef UART_TXQ_OVF_EN
        chk("ovf_set", 32'(ovf), 32'd1);
        wr_en = 1'b1;
        ovf_clr = 1'b1;
        step();
        wr_en = 1'b0;
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);
`endif
        tx_en = 1'b1;
        drain(16);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step();
                seen = seen | tx_start;
            end
            chk("no_dropped_launch", 32'(seen), 32'd0);
            chk("drained_empty", 32'(empty), 32'd1);
        end

        // Simultaneous write and pop at level 5
        tx_en = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        chk("l5_level", 32'(level), 32'd5);
        tx_en = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'hC5;
        q.push_back(8'hC5);
        step();
        wr_en = 1'b0;
        chk("l5_level_hold", 32'(level), 32'd5);
        chk("l5_start", 32'(tx_start), 32'd1);
        chk("l5_data", 32'(tx_data), 32'(q.pop_front()));
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        drain(5);
        chk("l5_empty", 32'(empty), 32'd1);

        // Reset while in WAIT with 4 bytes queued
        tx_en = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_level", 32'(level), 32'd4);
        rst = 1'b1;
        step();
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        q.delete();
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                step();
                seen = seen | tx_start;
            end
            chk("post_rst_no_start", 32'(seen), 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
